// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the EX-stage multiply/divide unit.
// Imported by the unit top and its testbench.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Whether operand a (opnd_b=0) or operand b (opnd_b=1) is treated as signed.
    function automatic logic is_signed(input logic [2:0] f3, input logic opnd_b);
        if (f3[2]) begin
            return ~f3[0];
        end
        return opnd_b ? ~f3[1] : ~(f3[1] & f3[0]);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The EX stage is the master; the unit is the slave.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic [RD_W-1:0] i_rd;
    logic            i_flush;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic [RD_W-1:0] o_rd;
    logic            o_busy;

    modport master (
        output i_valid, i_funct3, i_op_a, i_op_b, i_rd, i_flush,
        input  o_ready, o_valid, o_result, o_rd, o_busy
    );

    modport slave (
        input  i_valid, i_funct3, i_op_a, i_op_b, i_rd, i_flush,
        output o_ready, o_valid, o_result, o_rd, o_busy
    );
endinterface

// File: rtl/div_restoring_step.sv
// One iteration of restoring division on unsigned magnitudes.
// Requires rem < divisor on entry, which keeps the trial difference within XLEN+1 bits.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    // diff[XLEN] set means the trial subtraction borrowed: restore.
    assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit, one result bit per cycle, with flush abort.
// Define MULDIV_FAST_MUL_EN to compute MUL* in a single cycle at accept.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        funct3_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              neg_reg, rem_neg_reg;
    logic [XLEN-1:0]   opnd_reg, result_reg;
    logic [2*XLEN-1:0] acc_reg;

    logic              accept, req_div, sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_result;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_next;
    logic [XLEN-1:0]   rem_next, quo_next, div_final;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] f3,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic neg);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign accept   = bus.i_valid & (state_reg == IDLE) & ~bus.i_flush;
    assign req_div  = is_div(bus.i_funct3);
    assign sign_a   = is_signed(bus.i_funct3, 1'b0) & bus.i_op_a[XLEN-1];
    assign sign_b   = is_signed(bus.i_funct3, 1'b1) & bus.i_op_b[XLEN-1];
    assign mag_a    = sign_a ? -bus.i_op_a : bus.i_op_a;
    assign mag_b    = sign_b ? -bus.i_op_b : bus.i_op_b;
    assign div_zero = req_div & (bus.i_op_b == '0);
    assign div_ovf  = req_div & ~bus.i_funct3[0] & (bus.i_op_a == MIN_VAL) & (bus.i_op_b == '1);

    always_comb begin
        special        = div_zero | div_ovf;
        special_result = '0;
        if (div_zero) begin
            special_result = bus.i_funct3[1] ? bus.i_op_a : '1;
        end else if (div_ovf) begin
            special_result = bus.i_funct3[1] ? '0 : MIN_VAL;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!req_div) begin
            special        = 1'b1;
            special_result = mul_pick(bus.i_funct3,
                                      {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b},
                                      sign_a ^ sign_b);
        end
`endif
    end

    // Shift-add: acc holds {partial product high, multiplier being shifted out}.
    assign mul_sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg & {XLEN{acc_reg[0]}}};
    assign mul_acc_next = {mul_sum, acc_reg[XLEN-1:1]};

    div_restoring_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc_reg[2*XLEN-1:XLEN]),
        .quo      (acc_reg[XLEN-1:0]),
        .divisor  (opnd_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign div_final = funct3_reg[1] ? (rem_neg_reg ? -rem_next : rem_next)
                                     : (neg_reg ? -quo_next : quo_next);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : (req_div ? DIV : MUL);
                end
            end
            MUL, DIV: begin
                if (bus.i_flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_reg == IDLE);
        bus.o_valid = (state_reg == DONE) & ~bus.i_flush;
        bus.o_busy  = (state_reg == MUL) | (state_reg == DIV) | accept;
    end

    assign bus.o_result = result_reg;
    assign bus.o_rd     = rd_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_reg     <= '0;
            funct3_reg  <= '0;
            rd_reg      <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
            opnd_reg    <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        funct3_reg  <= bus.i_funct3;
                        rd_reg      <= bus.i_rd;
                        cnt_reg     <= CNT_W'(XLEN - 1);
                        neg_reg     <= sign_a ^ sign_b;
                        rem_neg_reg <= sign_a;
                        opnd_reg    <= req_div ? mag_b : mag_a;
                        acc_reg     <= {{XLEN{1'b0}}, (req_div ? mag_a : mag_b)};
                        if (special) begin
                            result_reg <= special_result;
                        end
                    end
                end
                MUL: begin
                    acc_reg <= mul_acc_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        result_reg <= mul_pick(funct3_reg, mul_acc_next, neg_reg);
                    end
                end
                DIV: begin
                    acc_reg <= {rem_next, quo_next};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        result_reg <= div_final;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit (XLEN=32): arithmetic reference model plus
// scoreboard with per-cycle checking of valid/ready/busy/result timing.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    ex_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
        bit          killed;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] lit;
        bit          pin;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference results straight from the RV32M definitions, using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'b0, b};
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accept-cycle sample to the o_valid sample.
    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) special = 1'b1;
`endif
        return special ? 1 : XLEN + 1;
    endfunction

    // Compare process: every negedge, outputs must match what the pending scoreboard entry implies.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            check("rst_ready", bus.o_ready, 1);
            check("rst_valid", bus.o_valid, 0);
            check("rst_busy", bus.o_busy, 0);
            check("rst_result", bus.o_result, 0);
            check("rst_rd", bus.o_rd, 0);
        end else if (sb_q.size() == 0) begin
            check("idle_valid", bus.o_valid, 0);
            check("idle_ready", bus.o_ready, 1);
        end else if (sb_q[0].killed) begin
            check("killed_valid", bus.o_valid, 0);
            if (cyc >= sb_q[0].due) void'(sb_q.pop_front());
        end else if (cyc < sb_q[0].due) begin
            check("wait_valid", bus.o_valid, 0);
            check("wait_busy", bus.o_busy, 1);
            check("wait_ready", bus.o_ready, 0);
        end else begin
            check("done_valid", bus.o_valid, 1);
            check("done_result", bus.o_result, sb_q[0].res);
            check("done_rd", bus.o_rd, sb_q[0].rd);
            check("done_busy", bus.o_busy, 0);
            check("done_ready", bus.o_ready, 0);
            $display("txn cycle=%0d rd=%0d result=0x%08h expected=0x%08h",
                     cyc, bus.o_rd, bus.o_result, sb_q[0].res);
            void'(sb_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        int n;
        n = 0;
        bus.i_valid  = 1'b1;
        bus.i_funct3 = f3;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
        bus.i_rd     = rd;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_ready && n < 200);
        check("accept_ready", bus.o_ready, 1);
        check("accept_busy", bus.o_busy, 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        e.res    = model(f3, a, b);
        e.rd     = rd;
        e.due    = cyc + latency(f3, a, b);
        e.killed = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] lit, input bit pin);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.lit = lit; v.pin = pin;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_funct3 = '0;
        bus.i_op_a   = '0;
        bus.i_op_b   = '0;
        bus.i_rd     = '0;
        bus.i_flush  = 1'b0;

        add_vec(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1);
        add_vec(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1);
        add_vec(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd2,  32'hFFFF_FFFF, 1);
        add_vec(F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000, 1);
        add_vec(F3_MULH,   32'hFFFF_FFFB,  32'd3,         5'd4,  32'hFFFF_FFFF, 1);
        add_vec(F3_MUL,    32'h1234_5678,  32'h9ABC_DEF0, 5'd6,  32'h0,         0);
        add_vec(F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h0,         0);
        add_vec(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFD, 1);
        add_vec(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 1);
        add_vec(F3_DIVU,   32'd100,        32'd7,         5'd10, 32'd14,        1);
        add_vec(F3_REMU,   32'd100,        32'd7,         5'd11, 32'd2,         1);
        add_vec(F3_DIVU,   32'd100,        32'd0,         5'd12, 32'hFFFF_FFFF, 1);
        add_vec(F3_REMU,   32'd100,        32'd0,         5'd13, 32'd100,       1);
        add_vec(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        add_vec(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h0,         1);
        add_vec(F3_DIV,    32'd7,          32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 1);
        add_vec(F3_REM,    32'd7,          32'hFFFF_FFFE, 5'd17, 32'd1,         1);
        add_vec(F3_REM,    32'hFFFF_FFFB,  32'd0,         5'd18, 32'hFFFF_FFFB, 1);
        add_vec(F3_DIV,    32'h8000_0000,  32'd2,         5'd19, 32'hC000_0000, 1);
        add_vec(F3_REM,    32'h7FFF_FFFF,  32'h8000_0000, 5'd20, 32'h7FFF_FFFF, 1);
        add_vec(F3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd21, 32'hFFFF_FFFF, 1);
        add_vec(F3_DIVU,   32'h8765_4321,  32'h0000_1234, 5'd22, 32'h0,         0);

        foreach (vecs[i]) begin
            if (vecs[i].pin) check("model_pin", model(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].lit);
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            drain();
        end

        // Back-to-back: next request held high through the previous op's DONE cycle.
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(F3_REMU, 32'd100, 32'd0, 5'd7);
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        drain();

        // Flush in the 10th DIV cycle: no result, ready again next cycle.
        issue(F3_DIV, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;

        // Flush coinciding with DONE suppresses the pulse.
        issue(F3_DIVU, 32'd55, 32'd0, 5'd10);
        bus.i_flush = 1'b1;
        sb_q[0].killed = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        drain();

        // Request with flush in IDLE is not accepted.
        bus.i_valid  = 1'b1;
        bus.i_funct3 = F3_DIV;
        bus.i_op_a   = 32'd9;
        bus.i_op_b   = 32'd0;
        bus.i_flush  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("flush_idle_busy", bus.o_busy, 0);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        issue(F3_MUL, 32'h0001_0001, 32'h0000_0003, 5'd11);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(F3_MULH, 32'hFFFF_FFFB, 32'd3, 5'd12);
        drain();
        issue(F3_REMU, 32'd100, 32'd7, 5'd13);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
